// File: rtl/microwave_cook_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : microwave_pkg
//  Purpose  : Shared state codes, preset table and helpers for the microwave
//             cook-cycle controller.
//  Revision : 1.0  initial release
// ============================================================================
package microwave_pkg;

  // Highest magnetron power level the heat datapath accepts
  localparam int MAX_LEVEL = 15;

  // FSM state codes, also exported on state_o
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COOK  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  // Preset table: 01 -> 30 s / p8, 10 -> 60 s / p12, 11 -> 90 s / p15
  localparam logic [7:0] c_preset1_time  = 8'd30;
  localparam logic [7:0] c_preset2_time  = 8'd60;
  localparam logic [7:0] c_preset3_time  = 8'd90;
  localparam logic [3:0] c_preset1_power = 4'd8;
  localparam logic [3:0] c_preset2_power = 4'd12;
  localparam logic [3:0] c_preset3_power = 4'd15;

  function automatic logic [7:0] preset_time(input logic [1:0] sel);
    case (sel)
      2'b01:   return c_preset1_time;
      2'b10:   return c_preset2_time;
      2'b11:   return c_preset3_time;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [3:0] preset_power(input logic [1:0] sel);
    case (sel)
      2'b01:   return c_preset1_power;
      2'b10:   return c_preset2_power;
      2'b11:   return c_preset3_power;
      default: return 4'd0;
    endcase
  endfunction

endpackage : microwave_pkg
`default_nettype wire

// File: rtl/microwave_cook_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : microwave_cook_sched_if
//  Purpose  : Front-panel inputs and heat/lamp/status outputs of the cook
//             controller. The beep line exists only when COOK_BEEP_EN is set.
//  Revision : 1.0  initial release
// ============================================================================
interface microwave_cook_sched_if;
  logic       start;
  logic       door_open;
  logic       up;
  logic       down;
  logic [1:0] preset;
  logic [3:0] heat;
  logic       lamp_door;
  logic [7:0] remaining;
  logic       busy;
  logic       done;
  logic [2:0] state_o;
`ifdef COOK_BEEP_EN
  logic       beep;
`endif

  // Panel / supervisor side
  modport master (
    output start, door_open, up, down, preset,
`ifdef COOK_BEEP_EN
    input  beep,
`endif
    input  heat, lamp_door, remaining, busy, done, state_o
  );

  // Controller side
  modport slave (
    input  start, door_open, up, down, preset,
`ifdef COOK_BEEP_EN
    output beep,
`endif
    output heat, lamp_door, remaining, busy, done, state_o
  );
endinterface : microwave_cook_sched_if
`default_nettype wire

// File: rtl/microwave_cook_sched_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : mw_sec_prescaler
//  Purpose  : Divides clk down to a one-clock 1 s strobe. The count can be
//             cleared (restart a second) or frozen (enable low).
//  Revision : 1.0  initial release
// ============================================================================
module mw_sec_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic en,
  output logic      tick
);
  localparam int c_cnt_w = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Strobe on the last count of each second while counting is enabled
  assign tick = en & (r_cnt == c_last);

  // Count 0..TICK_DIV-1 while enabled; clear takes priority over counting
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_cnt_w'(1);
    end
  end
endmodule : mw_sec_prescaler
`default_nettype wire

// File: rtl/microwave_cook_sched.sv
`default_nettype none
// ============================================================================
//  Module   : microwave_cook_sched
//  Purpose  : Cook-cycle controller: panel edge detection, set time / power,
//             cook FSM (IDLE/COOK/PAUSE/DONE) and registered heat, lamp and
//             status outputs. Optional done-beep with macro COOK_BEEP_EN.
//  Revision : 1.0  initial release
// ============================================================================
module microwave_cook_sched
  import microwave_pkg::*;
#(
  parameter int TICK_DIV  = 100,
  parameter int TIME_STEP = 10,
  parameter int MAX_TIME  = 240,
  parameter int DEF_POWER = 10
`ifdef COOK_BEEP_EN
  , parameter int BEEP_SECS = 3
`endif
) (
  input wire logic              clk,
  input wire logic              reset,
  microwave_cook_sched_if.slave bus
);
  localparam logic [3:0] c_def_power =
    (DEF_POWER > MAX_LEVEL) ? 4'(MAX_LEVEL) : 4'(DEF_POWER);

  // Add one step, saturating at MAX_TIME
  function automatic logic [7:0] f_add_step(input logic [7:0] v);
    logic [8:0] s;
    s = {1'b0, v} + 9'(TIME_STEP);
    return (s > 9'(MAX_TIME)) ? 8'(MAX_TIME) : s[7:0];
  endfunction

  // Remove one step, saturating at zero
  function automatic logic [7:0] f_sub_step(input logic [7:0] v);
    return (v < 8'(TIME_STEP)) ? 8'd0 : v - 8'(TIME_STEP);
  endfunction

  state_t     r_state, w_state_nxt;
  logic [7:0] r_remaining, w_remaining_nxt, w_rem_dec;
  logic [3:0] r_power, w_power_nxt;
  logic       r_start_q, r_up_q, r_down_q;
  logic       w_start_edge, w_up_edge, w_down_edge;
  logic       w_ps_clear, w_ps_en, w_tick;
  logic [3:0] r_heat, w_heat_nxt;
  logic       r_lamp, w_lamp_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
`ifdef COOK_BEEP_EN
  localparam int c_beep_w = (BEEP_SECS > 1) ? $clog2(BEEP_SECS + 1) : 1;
  logic                r_door_q, w_door_edge;
  logic [c_beep_w-1:0] r_beep_cnt;
  logic                r_beep, w_beep_nxt;
`endif

  assign w_start_edge = bus.start & ~r_start_q;
  assign w_up_edge    = bus.up    & ~r_up_q;
  assign w_down_edge  = bus.down  & ~r_down_q;

  // Edge-detect history; reset loads live inputs so no edge appears at release
  always_ff @(posedge clk) begin
    r_start_q <= bus.start;
    r_up_q    <= bus.up;
    r_down_q  <= bus.down;
  end

`ifdef COOK_BEEP_EN
  assign w_door_edge = bus.door_open & ~r_door_q;

  // Door history for ending the beep early
  always_ff @(posedge clk) begin
    r_door_q <= bus.door_open;
  end

  // Counts elapsed seconds spent in DONE
  always_ff @(posedge clk) begin
    if (reset || w_state_nxt != ST_DONE) begin
      r_beep_cnt <= '0;
    end else if (r_state == ST_DONE && w_tick) begin
      r_beep_cnt <= r_beep_cnt + c_beep_w'(1);
    end
  end

  // Prescaler also times the beep while in DONE
  assign w_ps_en = ((r_state == ST_COOK) & ~bus.door_open) | (r_state == ST_DONE);
`else
  // Prescaler runs only while cooking with the door shut
  assign w_ps_en = (r_state == ST_COOK) & ~bus.door_open;
`endif

  mw_sec_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (reset),
    .clear (w_ps_clear),
    .en    (w_ps_en),
    .tick  (w_tick)
  );

  assign w_rem_dec = w_tick ? r_remaining - 8'd1 : r_remaining;

  // State register together with the set time and power it owns
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= 8'd0;
      r_power     <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_power     <= w_power_nxt;
    end
  end

  // Next-state decode plus time/power updates for each state
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_power_nxt     = r_power;
    w_ps_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A valid start wins over same-cycle time edits
        if (w_start_edge && !bus.door_open && r_remaining != 8'd0) begin
          w_state_nxt = ST_COOK;
          w_ps_clear  = 1'b1;
        end else if (bus.preset != 2'b00) begin
          w_remaining_nxt = preset_time(bus.preset);
          w_power_nxt     = preset_power(bus.preset);
        end else if (w_up_edge && !w_down_edge) begin
          w_remaining_nxt = f_add_step(r_remaining);
          w_power_nxt     = c_def_power;
        end else if (w_down_edge && !w_up_edge) begin
          w_remaining_nxt = f_sub_step(r_remaining);
        end
      end
      ST_COOK: begin
        // Open door freezes everything (prescaler is disabled, so no tick)
        if (bus.door_open) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_tick && r_remaining == 8'd1 && !w_up_edge) begin
          w_state_nxt     = ST_DONE;
          w_remaining_nxt = 8'd0;
          w_power_nxt     = 4'd0;
          w_ps_clear      = 1'b1;
        end else begin
          w_remaining_nxt = w_up_edge ? f_add_step(w_rem_dec) : w_rem_dec;
        end
      end
      ST_PAUSE: begin
        if (w_down_edge) begin
          w_state_nxt     = ST_IDLE;
          w_remaining_nxt = 8'd0;
          w_power_nxt     = 4'd0;
        end else if (w_start_edge && !bus.door_open) begin
          w_state_nxt = ST_COOK;
        end
      end
      ST_DONE: begin
`ifdef COOK_BEEP_EN
        if (w_start_edge || w_door_edge ||
            (w_tick && r_beep_cnt == c_beep_w'(BEEP_SECS - 1))) begin
          w_state_nxt = ST_IDLE;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_remaining_nxt = 8'd0;
        w_power_nxt     = 4'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs track it
  always_comb begin
    w_heat_nxt = (w_state_nxt == ST_COOK) ? w_power_nxt : 4'd0;
    w_lamp_nxt = bus.door_open | (w_state_nxt == ST_COOK);
    w_busy_nxt = (w_state_nxt == ST_COOK) | (w_state_nxt == ST_PAUSE);
    w_done_nxt = (w_state_nxt == ST_DONE) & (r_state != ST_DONE);
`ifdef COOK_BEEP_EN
    w_beep_nxt = (w_state_nxt == ST_DONE);
`endif
  end

  // Output registers; lamp follows the door even while in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_heat <= 4'd0;
      r_lamp <= bus.door_open;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef COOK_BEEP_EN
      r_beep <= 1'b0;
`endif
    end else begin
      r_heat <= w_heat_nxt;
      r_lamp <= w_lamp_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
`ifdef COOK_BEEP_EN
      r_beep <= w_beep_nxt;
`endif
    end
  end

  assign bus.heat      = r_heat;
  assign bus.lamp_door = r_lamp;
  assign bus.remaining = r_remaining;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.state_o   = r_state;
`ifdef COOK_BEEP_EN
  assign bus.beep      = r_beep;
`endif

endmodule : microwave_cook_sched
`default_nettype wire

// File: tb/tb_microwave_cook_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_microwave_cook_sched
//  Purpose  : Directed self-checking bench for microwave_cook_sched with
//             TICK_DIV=4 (4 clocks per second).
//  Revision : 1.0  initial release
// ============================================================================
module tb_microwave_cook_sched;
  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  localparam logic [31:0] IDLE = 0, COOK = 1, PAUSE = 2, DONE = 3;

  microwave_cook_sched_if bus ();

  microwave_cook_sched #(
    .TICK_DIV  (4),
    .TIME_STEP (10),
    .MAX_TIME  (240),
    .DEF_POWER (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_core(input string tag, input logic [31:0] st, input logic [31:0] rem,
                            input logic [31:0] heat, input logic [31:0] busy);
    check({tag, ".state"}, 32'(bus.state_o), st);
    check({tag, ".remaining"}, 32'(bus.remaining), rem);
    check({tag, ".heat"}, 32'(bus.heat), heat);
    check({tag, ".busy"}, 32'(bus.busy), busy);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.door_open = 1'b1; bus.up = 1'b0; bus.down = 1'b0; bus.preset = 2'b00;
    step(3);
    check_core("reset", IDLE, 0, 0, 0);
    check("reset.done", 32'(bus.done), 0);
    check("reset.lamp_door_open", 32'(bus.lamp_door), 1);
    bus.door_open = 1'b0;
    step(1);
    check("reset.lamp_door_closed", 32'(bus.lamp_door), 0);
    reset = 1'b0;
    step(1);

    // 1: up -> 10 s at p10, full cook run down to done
    bus.up = 1'b1; step(1);
    check_core("t1.set", IDLE, 10, 0, 0);
    bus.up = 1'b0; bus.start = 1'b1; step(1);
    check_core("t1.start", COOK, 10, 10, 1);
    check("t1.lamp", 32'(bus.lamp_door), 1);
    bus.start = 1'b0;
    step(4);
    check_core("t1.sec1", COOK, 9, 10, 1);
    step(35);
    check_core("t1.last", COOK, 1, 10, 1);
    step(1);
    check_core("t1.done", DONE, 0, 0, 0);
    check("t1.done_pulse", 32'(bus.done), 1);
    check("t1.lamp_off", 32'(bus.lamp_door), 0);
`ifdef COOK_BEEP_EN
    check("t1.beep_on", 32'(bus.beep), 1);
    step(11);
    check("t1.beep_hold_state", 32'(bus.state_o), DONE);
    check("t1.beep_hold", 32'(bus.beep), 1);
    check("t1.done_single", 32'(bus.done), 0);
    step(1);
    check("t1.beep_off", 32'(bus.beep), 0);
`else
    step(1);
`endif
    check_core("t1.idle", IDLE, 0, 0, 0);
    check("t1.done_clear", 32'(bus.done), 0);

    // 2: preset 60 s/p12, pause with door after 8 clocks, resume
    bus.preset = 2'b10; step(1);
    check_core("t2.preset", IDLE, 60, 0, 0);
    bus.preset = 2'b00; bus.start = 1'b1; step(1);
    check_core("t2.start", COOK, 60, 12, 1);
    bus.start = 1'b0;
    step(8);
    check_core("t2.cook8", COOK, 58, 12, 1);
    bus.door_open = 1'b1; step(1);
    check_core("t2.pause", PAUSE, 58, 0, 1);
    check("t2.pause_lamp", 32'(bus.lamp_door), 1);
    step(5);
    check_core("t2.held", PAUSE, 58, 0, 1);
    bus.door_open = 1'b0; step(1);
    check("t2.closed_lamp", 32'(bus.lamp_door), 0);
    bus.start = 1'b1; step(1);
    check_core("t2.resume", COOK, 58, 12, 1);
    bus.start = 1'b0;
    step(4);
    check("t2.resume_tick", 32'(bus.remaining), 57);
    // 5b: cancel from PAUSE with down
    bus.door_open = 1'b1; step(1);
    bus.door_open = 1'b0; bus.down = 1'b1; step(1);
    check_core("t5.cancel", IDLE, 0, 0, 0);
    bus.down = 1'b0; step(1);

    // Door opening on the final-second strobe: door wins, 1 s left
    bus.up = 1'b1; step(1);
    bus.up = 1'b0; bus.start = 1'b1; step(1);
    bus.start = 1'b0;
    step(39);
    check_core("race.before", COOK, 1, 10, 1);
    bus.door_open = 1'b1; step(1);
    check_core("race.pause", PAUSE, 1, 0, 1);
    check("race.no_done", 32'(bus.done), 0);
    bus.door_open = 1'b0; step(1);
    bus.down = 1'b1; step(1);
    bus.down = 1'b0; step(1);
    check_core("race.cancel", IDLE, 0, 0, 0);

    // 3: saturation at MAX_TIME and at zero
    for (int i = 0; i < 25; i++) begin
      bus.up = 1'b1; step(1);
      bus.up = 1'b0; step(1);
    end
    check("t3.sat_max", 32'(bus.remaining), 240);
    for (int i = 0; i < 25; i++) begin
      bus.down = 1'b1; step(1);
      bus.down = 1'b0; step(1);
    end
    check("t3.sat_zero", 32'(bus.remaining), 0);

    // 4: start ignored with zero time, and with door open
    bus.start = 1'b1; step(1);
    check_core("t4.zero_time", IDLE, 0, 0, 0);
    bus.start = 1'b0; bus.up = 1'b1; step(1);
    bus.up = 1'b0; bus.door_open = 1'b1; step(1);
    bus.start = 1'b1; step(1);
    check_core("t4.door_open", IDLE, 10, 0, 0);
    check("t4.lamp", 32'(bus.lamp_door), 1);
    bus.start = 1'b0; bus.door_open = 1'b0; step(1);

    // 5: up+down together is a no-op; preset beats up
    bus.up = 1'b1; bus.down = 1'b1; step(1);
    check("t5.updown", 32'(bus.remaining), 10);
    bus.up = 1'b0; bus.down = 1'b0; step(1);
    bus.preset = 2'b01; bus.up = 1'b1; step(1);
    check("t5.preset_wins", 32'(bus.remaining), 30);
    bus.preset = 2'b00; bus.up = 1'b0; step(1);

    // 6: up adds time during COOK, then reset mid-cycle
    bus.start = 1'b1; step(1);
    check_core("t6.start", COOK, 30, 8, 1);
    bus.start = 1'b0; bus.up = 1'b1; step(1);
    check("t6.cook_up", 32'(bus.remaining), 40);
    bus.up = 1'b0; step(2);
    reset = 1'b1; step(1);
    check_core("t6.reset", IDLE, 0, 0, 0);
    check("t6.reset_lamp", 32'(bus.lamp_door), 0);
    reset = 1'b0; step(2);
    check_core("t6.after", IDLE, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule : tb_microwave_cook_sched
`default_nettype wire
